// File: rtl/clock_div_pkg.sv
// Shared state encoding, default sizing and helpers for the clock divider
// controller.
package clock_div_pkg;

   typedef enum logic [1:0] {
      RUN   = 2'd0,
      DRAIN = 2'd1,
      QUIET = 2'd2
   } state_t;

   localparam int DEF_WIDTH        = 8;
   localparam int DEF_QUIET_CYCLES = 2;

   function automatic logic [31:0] half(input logic [31:0] n);
      return n >> 1;
   endfunction

endpackage

// File: rtl/clock_div_counter.sv
// Wrapping period counter for the clock divider: counts 0..limit-1, held at 0
// for limits below 2, with a synchronous load-to-zero and a terminal flag.
module clock_div_counter
   import clock_div_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             i_load_zero,
   input  logic             i_en,
   input  logic [WIDTH-1:0] i_limit,
   output logic [WIDTH-1:0] o_cnt,
   output logic             o_term
);

   logic [WIDTH-1:0] r_cnt;
   logic [WIDTH-1:0] w_cnt_nxt;
   logic             w_counting;

   assign w_counting = (i_limit >= WIDTH'(2));
   assign o_term     = w_counting && (r_cnt == (i_limit - WIDTH'(1)));
   assign o_cnt      = r_cnt;

   // Next count value.
   always_comb begin
      w_cnt_nxt = r_cnt;
      if (i_load_zero || !w_counting) begin
         w_cnt_nxt = '0;
      end else if (i_en) begin
         if (o_term) begin
            w_cnt_nxt = '0;
         end else begin
            w_cnt_nxt = r_cnt + WIDTH'(1);
         end
      end else begin
         w_cnt_nxt = r_cnt;
      end
   end

   // Count register.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         r_cnt <= '0;
      end else begin
         r_cnt <= w_cnt_nxt;
      end
   end

endmodule

// File: rtl/clock_div_ctrl.sv
// Clock divider control stage: drives ClockFlop d, ClockGater enable and ClockMux2
// select, sequencing divisor switches. Optional macro: CLKDIV_SWITCH_COUNT_EN.
module clock_div_ctrl
   import clock_div_pkg::*;
#(
   parameter int WIDTH        = DEF_WIDTH,
   parameter int RESET_DIV    = 2,
   parameter int QUIET_CYCLES = DEF_QUIET_CYCLES
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             div_valid,
   output logic             div_ready,
   input  logic [WIDTH-1:0] div_bits,
   output logic             flop_d,
   output logic             bypass_sel,
   output logic             gate_en,
   output logic [WIDTH-1:0] cur_div,
   output logic             busy
`ifdef CLKDIV_SWITCH_COUNT_EN
   ,
   output logic [15:0]      switch_count
`endif
);

   localparam logic [WIDTH-1:0] RST_DIV  = WIDTH'(RESET_DIV);
   localparam int               QW       = (QUIET_CYCLES > 1) ? $clog2(QUIET_CYCLES) : 1;
   localparam logic [QW-1:0]    Q_LOAD   = QW'(QUIET_CYCLES - 1);
   localparam logic             RST_GATE = (RST_DIV != '0);
   localparam logic             RST_BYP  = (RST_DIV == WIDTH'(1));

   state_t           r_state;
   state_t           w_state_nxt;
   logic [WIDTH-1:0] r_cur_div;
   logic [WIDTH-1:0] w_cur_div_nxt;
   logic [WIDTH-1:0] r_pend;
   logic [WIDTH-1:0] w_pend_nxt;
   logic [QW-1:0]    r_qcnt;
   logic [QW-1:0]    w_qcnt_nxt;
   logic             r_gate_en;
   logic             w_gate_nxt;
   logic             r_bypass_sel;
   logic             w_bypass_nxt;
   logic             r_busy;
   logic             w_busy_nxt;

   logic             w_cnt_en;
   logic             w_cnt_load0;
   logic [WIDTH-1:0] w_cnt;
   logic             w_term;
   logic             w_div_ge2;
   logic [WIDTH-1:0] w_half;

   clock_div_counter #(
      .WIDTH (WIDTH)
   ) u_counter (
      .clock       (clock),
      .reset       (reset),
      .i_load_zero (w_cnt_load0),
      .i_en        (w_cnt_en),
      .i_limit     (r_cur_div),
      .o_cnt       (w_cnt),
      .o_term      (w_term)
   );

   assign w_div_ge2  = (r_cur_div >= WIDTH'(2));
   assign w_half     = WIDTH'(half(32'(r_cur_div)));
   assign flop_d     = w_div_ge2 && (w_cnt < w_half);
   assign div_ready  = (r_state == RUN);
   assign bypass_sel = r_bypass_sel;
   assign gate_en    = r_gate_en;
   assign cur_div    = r_cur_div;
   assign busy       = r_busy;

   // Next-state and next-register values for the switch sequencer.
   always_comb begin
      w_state_nxt   = r_state;
      w_cur_div_nxt = r_cur_div;
      w_pend_nxt    = r_pend;
      w_qcnt_nxt    = r_qcnt;
      w_gate_nxt    = r_gate_en;
      w_bypass_nxt  = r_bypass_sel;
      w_busy_nxt    = r_busy;
      w_cnt_en      = 1'b0;
      w_cnt_load0   = 1'b0;
      case (r_state)
         RUN: begin
            if (div_valid) begin
               w_pend_nxt = div_bits;
               w_busy_nxt = 1'b1;
               if (w_term) begin
                  // Accepted on the last cycle of a period: flop_d is already low.
                  w_state_nxt = QUIET;
                  w_gate_nxt  = 1'b0;
                  w_qcnt_nxt  = Q_LOAD;
               end else begin
                  w_state_nxt = DRAIN;
                  w_cnt_en    = 1'b1;
               end
            end else begin
               w_cnt_en = 1'b1;
            end
         end
         DRAIN: begin
            if (w_term || !w_div_ge2) begin
               // Freeze the counter on N-1 so flop_d stays low while gated off.
               w_state_nxt = QUIET;
               w_gate_nxt  = 1'b0;
               w_qcnt_nxt  = Q_LOAD;
            end else begin
               w_cnt_en = 1'b1;
            end
         end
         QUIET: begin
            w_bypass_nxt = (r_pend == WIDTH'(1));
            if (r_qcnt == '0) begin
               w_state_nxt   = RUN;
               w_cur_div_nxt = r_pend;
               w_cnt_load0   = 1'b1;
               w_gate_nxt    = (r_pend != '0);
               w_busy_nxt    = 1'b0;
            end else begin
               w_qcnt_nxt = r_qcnt - QW'(1);
            end
         end
         default: begin
            w_state_nxt = RUN;
            w_busy_nxt  = 1'b0;
            w_cnt_load0 = 1'b1;
         end
      endcase
   end

   // Sequencer state and clock-control registers.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         r_state      <= RUN;
         r_cur_div    <= RST_DIV;
         r_pend       <= RST_DIV;
         r_qcnt       <= '0;
         r_gate_en    <= RST_GATE;
         r_bypass_sel <= RST_BYP;
         r_busy       <= 1'b0;
      end else begin
         r_state      <= w_state_nxt;
         r_cur_div    <= w_cur_div_nxt;
         r_pend       <= w_pend_nxt;
         r_qcnt       <= w_qcnt_nxt;
         r_gate_en    <= w_gate_nxt;
         r_bypass_sel <= w_bypass_nxt;
         r_busy       <= w_busy_nxt;
      end
   end

`ifdef CLKDIV_SWITCH_COUNT_EN
   logic [15:0] r_switch_count;

   assign switch_count = r_switch_count;

   // Completed-switch counter, bumped on each return to RUN from QUIET.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         r_switch_count <= 16'd0;
      end else if ((r_state == QUIET) && (r_qcnt == '0)) begin
         r_switch_count <= r_switch_count + 16'd1;
      end else begin
         r_switch_count <= r_switch_count;
      end
   end
`endif

endmodule

// File: tb/tb_clock_div_ctrl.sv
// Self-checking bench for clock_div_ctrl: cycle-exact vector table plus
// hand-written sequences for held requests and reset during a switch.
module tb_clock_div_ctrl;

   logic       clock = 1'b0;
   logic       reset;
   logic       div_valid;
   logic [7:0] div_bits;
   logic       div_ready;
   logic       flop_d;
   logic       bypass_sel;
   logic       gate_en;
   logic [7:0] cur_div;
   logic       busy;
`ifdef CLKDIV_SWITCH_COUNT_EN
   logic [15:0] switch_count;
`endif

   int checks = 0;
   int errors = 0;
   int viol   = 0;

   typedef struct packed {
      logic       v;
      logic [7:0] bits;
      logic       fd;
      logic       g;
      logic       b;
      logic       r;
      logic       bz;
      logic [7:0] cd;
   } vec_t;

   vec_t tbl[$];

   always #5 clock = ~clock;

   clock_div_ctrl #(
      .WIDTH        (8),
      .RESET_DIV    (2),
      .QUIET_CYCLES (2)
   ) dut (
      .clock      (clock),
      .reset      (reset),
      .div_valid  (div_valid),
      .div_ready  (div_ready),
      .div_bits   (div_bits),
      .flop_d     (flop_d),
      .bypass_sel (bypass_sel),
      .gate_en    (gate_en),
      .cur_div    (cur_div),
      .busy       (busy)
`ifdef CLKDIV_SWITCH_COUNT_EN
      ,
      .switch_count (switch_count)
`endif
   );

   task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic add(input logic v, input logic [7:0] bits, input logic fd, input logic g,
                      input logic b, input logic r, input logic bz, input logic [7:0] cd);
      tbl.push_back({v, bits, fd, g, b, r, bz, cd});
   endtask

   // The mux select must only move while the gate is closed on both sides.
   logic mon_prev_b;
   logic mon_prev_g;
   logic mon_armed = 1'b0;
   always @(negedge clock) begin
      if (reset === 1'b1) begin
         if (mon_armed && (bypass_sel !== mon_prev_b) && (gate_en || mon_prev_g)) begin
            viol <= viol + 1;
         end
         mon_armed <= 1'b1;
      end else begin
         mon_armed <= 1'b0;
      end
      mon_prev_b <= bypass_sel;
      mon_prev_g <= gate_en;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      logic xfer;
      logic prev_busy;
      int   n_done;
      int   n_xfer;

      // v  bits   fd g  b  r  bz cd
      add(0, 8'd0, 0, 1, 0, 1, 0, 8'd2);   // N=2 free running
      add(0, 8'd0, 1, 1, 0, 1, 0, 8'd2);
      add(0, 8'd0, 0, 1, 0, 1, 0, 8'd2);
      add(0, 8'd0, 1, 1, 0, 1, 0, 8'd2);
      add(1, 8'd5, 0, 1, 0, 0, 1, 8'd2);   // accept 5 at cnt=0 -> DRAIN
      add(0, 8'd0, 0, 0, 0, 0, 1, 8'd2);   // QUIET
      add(0, 8'd0, 0, 0, 0, 0, 1, 8'd2);
      add(0, 8'd0, 1, 1, 0, 1, 0, 8'd5);   // RUN with N=5, cnt=0
      add(0, 8'd0, 1, 1, 0, 1, 0, 8'd5);
      add(0, 8'd0, 0, 1, 0, 1, 0, 8'd5);
      add(0, 8'd0, 0, 1, 0, 1, 0, 8'd5);
      add(0, 8'd0, 0, 1, 0, 1, 0, 8'd5);
      add(0, 8'd0, 1, 1, 0, 1, 0, 8'd5);
      add(0, 8'd0, 1, 1, 0, 1, 0, 8'd5);
      add(0, 8'd0, 0, 1, 0, 1, 0, 8'd5);   // cnt=2
      add(1, 8'd1, 0, 1, 0, 0, 1, 8'd5);   // accept 1 -> DRAIN two cycles
      add(0, 8'd0, 0, 1, 0, 0, 1, 8'd5);
      add(0, 8'd0, 0, 0, 0, 0, 1, 8'd5);
      add(0, 8'd0, 0, 0, 1, 0, 1, 8'd5);   // bypass rises while gated
      add(0, 8'd0, 0, 1, 1, 1, 0, 8'd1);
      add(0, 8'd0, 0, 1, 1, 1, 0, 8'd1);
      add(0, 8'd0, 0, 1, 1, 1, 0, 8'd1);
      add(1, 8'd0, 0, 1, 1, 0, 1, 8'd1);   // accept 0, valid held
      add(1, 8'd0, 0, 0, 1, 0, 1, 8'd1);
      add(1, 8'd0, 0, 0, 0, 0, 1, 8'd1);
      add(1, 8'd0, 0, 0, 0, 1, 0, 8'd0);
      add(0, 8'd0, 0, 0, 0, 1, 0, 8'd0);   // stopped
      add(0, 8'd0, 0, 0, 0, 1, 0, 8'd0);
      add(1, 8'd3, 0, 0, 0, 0, 1, 8'd0);   // accept 3
      add(0, 8'd0, 0, 0, 0, 0, 1, 8'd0);
      add(0, 8'd0, 0, 0, 0, 0, 1, 8'd0);
      add(0, 8'd0, 1, 1, 0, 1, 0, 8'd3);   // N=3: high 1 of 3
      add(0, 8'd0, 0, 1, 0, 1, 0, 8'd3);
      add(0, 8'd0, 0, 1, 0, 1, 0, 8'd3);
      add(0, 8'd0, 1, 1, 0, 1, 0, 8'd3);
      add(0, 8'd0, 0, 1, 0, 1, 0, 8'd3);
      add(0, 8'd0, 0, 1, 0, 1, 0, 8'd3);

      reset     = 1'b0;
      div_valid = 1'b0;
      div_bits  = 8'd0;
      repeat (2) @(posedge clock);
      #1;
      check("reset cur_div", 16'(cur_div), 16'd2);
      check("reset gate_en", 16'(gate_en), 16'd1);
      check("reset bypass_sel", 16'(bypass_sel), 16'd0);
      check("reset div_ready", 16'(div_ready), 16'd1);
      check("reset busy", 16'(busy), 16'd0);
`ifdef CLKDIV_SWITCH_COUNT_EN
      check("reset switch_count", switch_count, 16'd0);
`endif
      reset = 1'b1;
      check("first-edge flop_d", 16'(flop_d), 16'd1);

      for (int i = 0; i < tbl.size(); i++) begin
         div_valid = tbl[i].v;
         div_bits  = tbl[i].bits;
         @(posedge clock);
         #1;
         check($sformatf("row%0d flop_d", i), 16'(flop_d), 16'(tbl[i].fd));
         check($sformatf("row%0d gate_en", i), 16'(gate_en), 16'(tbl[i].g));
         check($sformatf("row%0d bypass_sel", i), 16'(bypass_sel), 16'(tbl[i].b));
         check($sformatf("row%0d div_ready", i), 16'(div_ready), 16'(tbl[i].r));
         check($sformatf("row%0d busy", i), 16'(busy), 16'(tbl[i].bz));
         check($sformatf("row%0d cur_div", i), 16'(cur_div), 16'(tbl[i].cd));
      end
      div_valid = 1'b0;

      // div_valid held high, alternating 4/6 after each accepted transfer.
      div_valid = 1'b1;
      div_bits  = 8'd4;
      n_done    = 0;
      n_xfer    = 0;
      prev_busy = busy;
      for (int cyc = 0; cyc < 200 && n_done < 4; cyc++) begin
         xfer = div_ready;
         @(posedge clock);
         #1;
         if (xfer) begin
            n_xfer++;
            check("alt ready after transfer", 16'(div_ready), 16'd0);
            div_bits = (div_bits == 8'd4) ? 8'd6 : 8'd4;
         end
         check("alt ready during switch", 16'(div_ready & busy), 16'd0);
         if (prev_busy && !busy) begin
            check("alt cur_div", 16'(cur_div), (n_done % 2 == 0) ? 16'd4 : 16'd6);
            n_done++;
         end
         prev_busy = busy;
      end
      div_valid = 1'b0;
      check("alt switches completed", 16'(n_done), 16'd4);
      check("alt transfers", 16'(n_xfer), 16'd4);
`ifdef CLKDIV_SWITCH_COUNT_EN
      check("switch_count total", switch_count, 16'd8);
`endif

      // Reset in the middle of a 2 -> 7 switch.
      reset = 1'b0;
      @(posedge clock);
      #1;
      reset     = 1'b1;
      div_valid = 1'b1;
      div_bits  = 8'd7;
      @(posedge clock);
      #1;
      check("r7 busy in DRAIN", 16'(busy), 16'd1);
      div_valid = 1'b0;
      @(posedge clock);
      #1;
      check("r7 gate_en in QUIET", 16'(gate_en), 16'd0);
      reset = 1'b0;
      #1;
      check("mid-switch reset cur_div", 16'(cur_div), 16'd2);
      check("mid-switch reset gate_en", 16'(gate_en), 16'd1);
      check("mid-switch reset busy", 16'(busy), 16'd0);
      check("mid-switch reset div_ready", 16'(div_ready), 16'd1);
      check("mid-switch reset bypass_sel", 16'(bypass_sel), 16'd0);
`ifdef CLKDIV_SWITCH_COUNT_EN
      check("mid-switch reset switch_count", switch_count, 16'd0);
`endif
      #1;
      reset = 1'b1;
      for (int k = 0; k < 4; k++) begin
         @(posedge clock);
         #1;
         check($sformatf("post-reset%0d flop_d", k), 16'(flop_d), (k % 2 == 0) ? 16'd0 : 16'd1);
         check($sformatf("post-reset%0d cur_div", k), 16'(cur_div), 16'd2);
         check($sformatf("post-reset%0d busy", k), 16'(busy), 16'd0);
      end

      check("bypass moved while gate open", 16'(viol), 16'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/clock_div_ctrl.md
Name: clock_div_ctrl

Overview:
- Control stage directly upstream of the clock primitives ClockFlop, ClockGater and ClockMux2.
- Runs on the fast source clock and generates the toggle pattern that a single ClockFlop turns into clock/N.
- Drives the gate enable and the bypass mux select.
- Sequences divisor changes so the gated, muxed output never produces a short pulse.

Parameters:
- WIDTH, 8, divisor width in bits.
- RESET_DIV, 2, divisor loaded at reset (0..2^WIDTH-1).
- QUIET_CYCLES, 2, source-clock cycles gate_en is held low during a switch (>=1).

Ports:
- clock  in  1  source clock; all state on posedge.
- reset  in  1  asynchronous, active-low reset.
- div_valid  in  1  new divisor offered.
- div_ready  out  1  controller can accept a divisor.
- div_bits  in  WIDTH  requested divisor N.
- flop_d  out  1  d input of the downstream ClockFlop.
- bypass_sel  out  1  ClockMux2 select; 1 = undivided clock, 0 = ClockFlop output.
- gate_en  out  1  ClockGater enable.
- cur_div  out  WIDTH  divisor currently in effect.
- busy  out  1  switch in progress.

Behaviour:
- Reset (reset low, async) sets:
  - cur_div = RESET_DIV, cnt = 0, state = RUN, div_ready = 1, busy = 0.
  - gate_en = (RESET_DIV != 0), bypass_sel = (RESET_DIV == 1).
- On reset deassertion, the counter starts on the first posedge.
- Counter cnt (WIDTH bits):
  - N >= 2: counts 0..N-1 and wraps to 0.
  - N = 0 or 1: held at 0.
- flop_d = (N >= 2) && (cnt < N>>1).
  - Decoded only from registers, so it is glitch-free at the ClockFlop sample point.
  - Divided output: period N, high floor(N/2) cycles. Odd N has duty < 50%, which is accepted.
- N = 1: bypass_sel = 1, flop_d = 0.
- N = 0: clock stopped; gate_en = 0, bypass_sel = 0.
- Handshake:
  - A transfer occurs on div_valid && div_ready.
  - div_ready = 1 only in RUN.
  - div_bits is sampled in the transfer cycle and held in a pending register.
  - div_valid may stay high; no further transfer until the state returns to RUN.
- States:
  - RUN: normal operation. On transfer, go to DRAIN; busy = 1, div_ready = 0.
  - DRAIN: wait for end of period.
    - N >= 2: leave when cnt == N-1 (flop_d already 0).
    - N in {0, 1}: leave after 1 cycle.
    - On exit, gate_en goes 0 and the state moves to QUIET with qcnt = QUIET_CYCLES-1.
  - QUIET: gate_en = 0, counting qcnt down.
    - Update bypass_sel from the pending divisor in the first QUIET cycle.
    - When qcnt == 0: load cur_div = pending, cnt = 0, gate_en = (pending != 0), busy = 0, state = RUN.
- A request equal to cur_div still runs the full sequence (no shortcut).
- Switch latency for N >= 2: (N-1-cnt at accept) + 1 + QUIET_CYCLES cycles.
- Reset mid-switch aborts the switch, discards pending, and restores the reset values immediately.
- gate_en, bypass_sel, flop_d and busy are each registered or pure decodes of registers. No combinational path exists from div_valid to any clock-control output.

Optional Feature:
- Macro CLKDIV_SWITCH_COUNT_EN.
- Defined:
  - Extra output port switch_count (16 bits, reset 0).
  - Increments on each RUN re-entry from QUIET and wraps at 0xFFFF -> 0.
- Undefined:
  - Port and counter are absent.
  - All other behaviour is identical.

Decomposition:
- Package clock_div_pkg:
  - State enum {RUN, DRAIN, QUIET}.
  - Default constants: WIDTH = 8, QUIET_CYCLES = 2.
  - Helper function half(N) = N>>1.
- One sub-module, clock_div_counter:
  - Wrapping counter with load-zero, enable, limit input and terminal flag (cnt == limit-1).
  - Instantiated once.

Test Plan:
- Reset with RESET_DIV=2, release -> flop_d toggles 1,0,1,0 from the first edge; gate_en = 1; bypass_sel = 0; div_ready = 1.
- Request N=5 at cnt=0 (from N=2) -> DRAIN 1 cycle, gate_en low for 2 cycles, then cur_div = 5 and flop_d pattern 1,1,0,0,0 repeating; busy high for exactly 3 cycles.
- Request N=1 -> bypass_sel rises only while gate_en = 0; after the switch, flop_d stays 0. Attach a PeriodMonitor with min 1000 ps at 1 GHz and confirm no violation.
- Request N=0 and hold -> gate_en stays 0. Then request N=3 -> gate_en returns high; period = 3 cycles, high 1 cycle.
- Keep div_valid high continuously with alternating values 4/6 -> one transfer per RUN entry; div_ready is never high during DRAIN or QUIET.
- Assert reset during QUIET of a 2->7 switch -> cur_div = 2, gate_en = 1, busy = 0 immediately. With CLKDIV_SWITCH_COUNT_EN defined, switch_count = 0.
